// File: rtl/heater_ctrl.sv
// heater_ctrl: thermostat sequencer with hysteresis, dwell limits and watchdogs.
// A fault latches until err_clear is seen while in FAULT.
module heater_ctrl #(
   parameter int TEMP_W  = 12,
   parameter int MIN_ON  = 50,
   parameter int MIN_OFF = 50,
   parameter int MAX_ON  = 4000,
   parameter int STALE   = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [TEMP_W-1:0] temp,
   input  logic              temp_valid,
   input  logic [TEMP_W-1:0] setpoint,
   input  logic [TEMP_W-1:0] hyst,
   input  logic              err_clear,
   output logic              heat_on,
   output logic              error,
   output logic [1:0]        fault_code
);

   localparam int DW = $clog2(MAX_ON + 1);
   localparam int SW = $clog2(STALE + 1);

   localparam logic [DW-1:0] D_SAT = DW'(MAX_ON);
   localparam logic [DW-1:0] D_TMO = DW'(MAX_ON - 1);
   localparam logic [DW-1:0] D_ON  = DW'(MIN_ON - 1);
   localparam logic [DW-1:0] D_OFF = DW'(MIN_OFF - 1);
   localparam logic [SW-1:0] S_SAT = SW'(STALE);
   localparam logic [SW-1:0] S_TMO = SW'(STALE - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_OFF   = 2'd1;
   localparam logic [1:0] ST_ON    = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_TMO   = 2'b01;
   localparam logic [1:0] FC_STALE = 2'b10;

   logic [1:0]        r_state;
   logic [1:0]        r_code;
   logic              r_heat;
   logic              r_err;
   logic              r_cold;
   logic              r_hot;
   logic [DW-1:0]     r_dcnt;
   logic [SW-1:0]     r_scnt;

   logic [1:0]        w_next;
   logic [1:0]        w_code;
   logic              w_run;
   logic              w_stale;
   logic signed [TEMP_W:0] w_thr;
   logic              w_cold;
   logic              w_hot;
   logic              w_flag_clr;
   logic              w_start;

   // Threshold is computed one bit wider so a negative result blocks cold.
   assign w_thr   = $signed({1'b0, setpoint}) - $signed({1'b0, hyst});
   assign w_cold  = !w_thr[TEMP_W] && ($signed({1'b0, temp}) < w_thr);
   assign w_hot   = (temp >= setpoint);

   assign w_run   = (r_state == ST_OFF) || (r_state == ST_ON);
   assign w_stale = (r_scnt == S_TMO) && !temp_valid;

   assign w_flag_clr = (r_state == ST_FAULT) && (w_next == ST_IDLE);
   assign w_start    = (r_state == ST_IDLE) && (w_next == ST_OFF);

   always_comb begin
      w_next = r_state;
      w_code = r_code;
      case (r_state)
         ST_IDLE: begin
            if (enable) w_next = ST_OFF;
         end
         ST_OFF: begin
            if (!enable) begin
               w_next = ST_IDLE;
            end else if (w_stale) begin
               w_next = ST_FAULT;
               w_code = FC_STALE;
            end else if ((r_dcnt >= D_OFF) && r_cold) begin
               w_next = ST_ON;
            end
         end
         ST_ON: begin
            if (!enable) begin
               w_next = ST_IDLE;
            end else if (r_dcnt == D_TMO) begin
               w_next = ST_FAULT;
               w_code = FC_TMO;
            end else if (w_stale) begin
               w_next = ST_FAULT;
               w_code = FC_STALE;
            end else if ((r_dcnt >= D_ON) && r_hot) begin
               w_next = ST_OFF;
            end
         end
         ST_FAULT: begin
            if (err_clear) begin
               w_next = ST_IDLE;
               w_code = FC_NONE;
            end
         end
         default: begin
            w_next = ST_IDLE;
            w_code = FC_NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_code  <= FC_NONE;
         r_heat  <= 1'b0;
         r_err   <= 1'b0;
         r_cold  <= 1'b0;
         r_hot   <= 1'b0;
         r_dcnt  <= '0;
         r_scnt  <= '0;
      end else begin
         r_state <= w_next;
         r_code  <= w_code;
         r_heat  <= (w_next == ST_ON);
         r_err   <= (w_next == ST_FAULT);

         if (w_next != r_state) r_dcnt <= '0;
         else if (w_run && (r_dcnt != D_SAT)) r_dcnt <= r_dcnt + 1'b1;

         if (temp_valid || w_start) r_scnt <= '0;
         else if (w_run && (r_scnt != S_SAT)) r_scnt <= r_scnt + 1'b1;

         if (w_flag_clr) begin
            r_cold <= 1'b0;
            r_hot  <= 1'b0;
         end else if (temp_valid) begin
            r_cold <= w_cold;
            r_hot  <= w_hot;
         end
      end
   end

   assign heat_on    = r_heat;
   assign error      = r_err;
   assign fault_code = r_code;

endmodule

// File: doc/heater_ctrl.md
# heater_ctrl

Thermostat sequencer for the heater element. It turns the heater on and off from sampled temperature readings, with hysteresis and minimum on/off dwell times. A maximum-on-time watchdog and a stale-sensor watchdog force a latched fault, and the fault holds until `err_clear` is pulsed. The block sits between the temperature sampler and the heater drive, and exposes the same `error` / `err_clear` pair the heater bench already exercises.

## Interface
- `TEMP_W`, 12, width of temperature, setpoint and hysteresis values (unsigned).
- `MIN_ON`, 50, minimum cycles `heat_on` stays high once asserted (≥1).
- `MIN_OFF`, 50, minimum cycles `heat_on` stays low before re-asserting (≥1).
- `MAX_ON`, 4000, cycles of continuous `heat_on` that trigger a timeout fault (> `MIN_ON`).
- `STALE`, 1000, cycles without `temp_valid` in OFF/ON that trigger a sensor fault.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request; low forces IDLE from OFF or ON.
- `temp`  in  TEMP_W  current temperature sample.
- `temp_valid`  in  1  single-cycle qualifier for `temp`.
- `setpoint`  in  TEMP_W  target temperature; quasi-static.
- `hyst`  in  TEMP_W  hysteresis band below the setpoint; quasi-static.
- `err_clear`  in  1  fault acknowledge; acted on only in FAULT.
- `heat_on`  out  1  heater drive, registered.
- `error`  out  1  latched fault flag, registered.
- `fault_code`  out  2  00 none, 01 max-on timeout, 10 stale sensor; held while `error`=1.

## Operation
- States:
  - IDLE: `heat_on`=0.
  - OFF: `heat_on`=0.
  - ON: `heat_on`=1.
  - FAULT: `heat_on`=0, `error`=1.
- Flags `cold` and `hot` are registered and update only on `temp_valid`:
  - `cold` = `temp` < `setpoint` − `hyst`, evaluated at TEMP_W+1 bits signed. If `setpoint` < `hyst`, `cold`=0 (no underflow).
  - `hot` = `temp` ≥ `setpoint`.
  - Both flags clear on reset and on FAULT→IDLE.
- Dwell counter `dcnt`: cleared on every state entry, increments each cycle in OFF/ON, saturates at `MAX_ON`. Width is $clog2(MAX_ON+1).
- Stale counter `scnt`: cleared on `temp_valid` and on IDLE→OFF; otherwise increments in OFF/ON and saturates at `STALE`.
- Transitions, evaluated each cycle, with the highest priority listed first:
  - IDLE → OFF when `enable`=1.
  - OFF/ON → IDLE when `enable`=0. This overrides `MIN_ON`/`MIN_OFF`.
  - ON → FAULT (code 01) when `dcnt`=`MAX_ON`−1.
  - OFF/ON → FAULT (code 10) when `scnt`=`STALE`−1 and `temp_valid`=0.
  - OFF → ON when `dcnt` ≥ `MIN_OFF`−1 and `cold`=1.
  - ON → OFF when `dcnt` ≥ `MIN_ON`−1 and `hot`=1.
  - FAULT → IDLE when `err_clear`=1. `err_clear` is ignored in every other state.
- Faults take priority over a normal ON→OFF exit in the same cycle.
- `fault_code` is written on FAULT entry and cleared on FAULT exit.
- Flags sample on the same edge as `temp_valid`. A sample at edge t is first visible to transitions at edge t+1.

## Timing
- Reset values: state IDLE, `heat_on`=0, `error`=0, `fault_code`=00, `cold`=`hot`=0, `dcnt`=`scnt`=0.
- Reset asserted mid-operation (any state, including FAULT) returns to reset values on the next edge; no fault survives reset.
- All outputs are registered and change on the edge following the transition decision; there is no combinational input-to-output path.
- Dwell bounds:
  - `heat_on` is low for ≥ `MIN_OFF` cycles between pulses.
  - `heat_on` is high for ≥ `MIN_ON` cycles unless `enable` drops or a fault occurs.
  - `heat_on` is never high for more than `MAX_ON` consecutive cycles.
- Earliest `heat_on` after `enable` rises from IDLE with `cold` already set: 1 + `MIN_OFF` cycles.
- FAULT entry: `error`=1 and `heat_on`=0 on the same edge.
- FAULT exit: `error`=0 on the edge after `err_clear` is sampled high. The block then passes through IDLE; if `enable`=1 it enters OFF one cycle later.
- `err_clear` held high for multiple cycles has no additional effect.

## Test plan
- Reset: hold `reset` 10 cycles with random inputs → `heat_on`=0, `error`=0, `fault_code`=00 throughout and on release.
- Normal cycle:
  - Setup: `setpoint`=200, `hyst`=10, `temp`=100 valid every 10 cycles, `enable`=1.
  - Expected: `heat_on` rises 51 cycles after `enable`.
  - Then drive `temp`=205 at ON-cycle 20 → `heat_on` falls exactly after ON-cycle 50 (`MIN_ON` honoured).
  - Then drive `temp`=185 → `heat_on` re-rises no earlier than 50 cycles after the fall.
- Timeout: keep `temp`=100 valid every 10 cycles → after 4000 cycles of `heat_on`, `error`=1, `fault_code`=01, `heat_on`=0. Pulse `err_clear` at cycle 4600 → `error`=0 next edge, then OFF→ON after 50 more cycles.
- Stale sensor: in ON, stop `temp_valid` → FAULT with `fault_code`=10 exactly 1000 cycles after the last valid sample. `err_clear` pulsed before the fault occurs has no effect.
- Enable drop: deassert `enable` at ON-cycle 5 → `heat_on`=0 on the next edge, state IDLE, `error` stays 0.
- Underflow guard: `setpoint`=5, `hyst`=10, `temp`=0 valid → `cold`=0 and `heat_on` never asserts over 2000 cycles. Apply reset at ON-cycle 30 of a separate run → all outputs return to reset values next edge.
